// File: rtl/lsu_engine_if.sv
// Core-side request/response and memory-side bus of the load/store unit.
interface lsu_engine_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;
  logic             mem_read_en;
  logic             mem_write_en;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_write_data;
  logic [WIDTH-1:0] mem_read_data;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_read_en, mem_write_en, mem_addr, mem_write_data
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_read_en, mem_write_en, mem_addr, mem_write_data
  );
endinterface

// File: rtl/lsu_engine.sv
// Load/store unit: alignment checking, sub-word load extension and
// read-modify-write for byte/halfword stores on a word-only memory.
module lsu_engine #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  lsu_engine_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] addr_q;
  logic             we_q;
  logic [2:0]       funct3_q;
  logic [15:0]      wdata_q;

  function automatic logic is_err(input logic we, input logic [2:0] f3,
                                  input logic [1:0] a);
    logic e;
    e = 1'b1;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = a[0];
      3'b010:  e = (a != 2'b00);
      3'b100:  e = we;
      3'b101:  e = we | a[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] extract(input logic [2:0] f3,
                                               input logic [1:0] a,
                                               input logic [WIDTH-1:0] w);
    logic [7:0]       b;
    logic [15:0]      h;
    logic [WIDTH-1:0] r;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{(WIDTH-8){b[7]}}, b};
      3'b001:  r = {{(WIDTH-16){h[15]}}, h};
      3'b100:  r = {{(WIDTH-8){1'b0}}, b};
      3'b101:  r = {{(WIDTH-16){1'b0}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] merge(input logic [2:0] f3,
                                             input logic [1:0] a,
                                             input logic [WIDTH-1:0] w,
                                             input logic [15:0] d);
    logic [WIDTH-1:0] r;
    r = w;
    if (f3 == 3'b000) r[{a, 3'b000} +: 8] = d[7:0];
    else              r[{a[1], 4'b0000} +: 16] = d;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] word_addr(input logic [WIDTH-1:0] a);
    return {2'b00, a[WIDTH-1:2]};
  endfunction

  assign bus.req_ready = (state == S_IDLE);

  // The word read in READ feeds the response/merge registers directly on the
  // same edge, so no separate captured-word register is kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= S_IDLE;
      addr_q             <= '0;
      we_q               <= 1'b0;
      funct3_q           <= '0;
      wdata_q            <= '0;
      bus.resp_valid     <= 1'b0;
      bus.resp_rdata     <= '0;
      bus.resp_err       <= 1'b0;
      bus.mem_read_en    <= 1'b0;
      bus.mem_write_en   <= 1'b0;
      bus.mem_addr       <= '0;
      bus.mem_write_data <= '0;
    end else begin
      bus.resp_valid     <= 1'b0;
      bus.resp_rdata     <= '0;
      bus.resp_err       <= 1'b0;
      bus.mem_read_en    <= 1'b0;
      bus.mem_write_en   <= 1'b0;
      bus.mem_addr       <= '0;
      bus.mem_write_data <= '0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            addr_q   <= bus.req_addr;
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            wdata_q  <= bus.req_wdata[15:0];
            if (is_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
              state          <= S_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
            end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
              state              <= S_WRITE;
              bus.mem_write_en   <= 1'b1;
              bus.mem_addr       <= word_addr(bus.req_addr);
              bus.mem_write_data <= bus.req_wdata;
            end else begin
              state           <= S_READ;
              bus.mem_read_en <= 1'b1;
              bus.mem_addr    <= word_addr(bus.req_addr);
            end
          end
        end
        S_READ: begin
          if (we_q) begin
            state              <= S_WRITE;
            bus.mem_write_en   <= 1'b1;
            bus.mem_addr       <= word_addr(addr_q);
            bus.mem_write_data <= merge(funct3_q, addr_q[1:0], bus.mem_read_data, wdata_q);
          end else begin
            state          <= S_RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= extract(funct3_q, addr_q[1:0], bus.mem_read_data);
          end
        end
        S_WRITE: begin
          state          <= S_RESP;
          bus.resp_valid <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_engine.sv
// Directed self-checking bench for lsu_engine with a small word memory model.
module tb_lsu_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  logic [31:0] mem [64];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = '0;
  logic [31:0] poke_data = '0;

  lsu_engine_if #(.WIDTH(32)) bus ();

  lsu_engine #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_read_data = mem[bus.mem_addr[5:0]];

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_data;
    else if (bus.mem_write_en) mem[bus.mem_addr[5:0]] <= bus.mem_write_data;
  end

  task automatic poke(input logic [5:0] idx, input logic [31:0] d);
    @(negedge clk);
    poke_idx = idx; poke_data = d; poke_en = 1'b1;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  // Presents a request and returns just after its accept edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output bit ok);
    bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = d;
    bus.req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) ok = 1'b1;
    end
    if (ok) @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.req_ready); else passed++;
    total++; if ({bus.resp_valid, bus.resp_err, bus.mem_read_en, bus.mem_write_en} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000", {bus.resp_valid, bus.resp_err, bus.mem_read_en, bus.mem_write_en}); else passed++;
    total++; if ({bus.resp_rdata, bus.mem_addr, bus.mem_write_data} !== 96'h0)
      $display("FAIL reset_data: got %h want 0", {bus.resp_rdata, bus.mem_addr, bus.mem_write_data}); else passed++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_sw_lw();
    bit ok;
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, ok);
    total++; if (!ok) $display("FAIL sw_accept: got timeout want accept"); else passed++;
    @(negedge clk);
    total++; if ({bus.mem_write_en, bus.mem_read_en, bus.resp_valid} !== 3'b100)
      $display("FAIL sw_c1_en: got %b want 100", {bus.mem_write_en, bus.mem_read_en, bus.resp_valid}); else passed++;
    total++; if (bus.mem_addr !== 32'h4) $display("FAIL sw_c1_addr: got %h want 4", bus.mem_addr); else passed++;
    total++; if (bus.mem_write_data !== 32'hDEADBEEF) $display("FAIL sw_c1_wdata: got %h want deadbeef", bus.mem_write_data); else passed++;
    @(negedge clk);
    total++; if ({bus.resp_valid, bus.resp_err, bus.mem_write_en, bus.req_ready} !== 4'b1000)
      $display("FAIL sw_c2_resp: got %b want 1000", {bus.resp_valid, bus.resp_err, bus.mem_write_en, bus.req_ready}); else passed++;
    total++; if (bus.resp_rdata !== 32'h0) $display("FAIL sw_c2_rdata: got %h want 0", bus.resp_rdata); else passed++;
    issue(1'b0, 3'b010, 32'h10, 32'h0, ok);
    total++; if (!ok) $display("FAIL lw_accept: got timeout want accept"); else passed++;
    @(negedge clk);
    total++; if ({bus.mem_read_en, bus.mem_write_en, bus.resp_valid} !== 3'b100 || bus.mem_addr !== 32'h4)
      $display("FAIL lw_c1: got en=%b addr=%h want 100/4", {bus.mem_read_en, bus.mem_write_en, bus.resp_valid}, bus.mem_addr); else passed++;
    @(negedge clk);
    total++; if ({bus.resp_valid, bus.resp_err} !== 2'b10 || bus.resp_rdata !== 32'hDEADBEEF)
      $display("FAIL lw_c2: got v/e=%b rdata=%h want 10/deadbeef", {bus.resp_valid, bus.resp_err}, bus.resp_rdata); else passed++;
    @(negedge clk);
    total++; if ({bus.resp_valid, bus.req_ready} !== 2'b01 || bus.resp_rdata !== 32'h0)
      $display("FAIL lw_c3: got v/r=%b rdata=%h want 01/0", {bus.resp_valid, bus.req_ready}, bus.resp_rdata); else passed++;
  endtask

  task automatic test_sb_rmw();
    bit ok;
    poke(6'd4, 32'h11223344);
    issue(1'b1, 3'b000, 32'h12, 32'hFFFFFFAB, ok);
    total++; if (!ok) $display("FAIL sb_accept: got timeout want accept"); else passed++;
    @(negedge clk);
    total++; if ({bus.mem_read_en, bus.mem_write_en, bus.resp_valid} !== 3'b100 || bus.mem_addr !== 32'h4)
      $display("FAIL sb_c1_read: got en=%b addr=%h want 100/4", {bus.mem_read_en, bus.mem_write_en, bus.resp_valid}, bus.mem_addr); else passed++;
    @(negedge clk);
    total++; if ({bus.mem_read_en, bus.mem_write_en, bus.resp_valid} !== 3'b010 || bus.mem_addr !== 32'h4)
      $display("FAIL sb_c2_write: got en=%b addr=%h want 010/4", {bus.mem_read_en, bus.mem_write_en, bus.resp_valid}, bus.mem_addr); else passed++;
    total++; if (bus.mem_write_data !== 32'h11AB3344) $display("FAIL sb_c2_wdata: got %h want 11ab3344", bus.mem_write_data); else passed++;
    @(negedge clk);
    total++; if ({bus.resp_valid, bus.resp_err, bus.mem_write_en} !== 3'b100 || bus.resp_rdata !== 32'h0)
      $display("FAIL sb_c3_resp: got %b rdata=%h want 100/0", {bus.resp_valid, bus.resp_err, bus.mem_write_en}, bus.resp_rdata); else passed++;
    total++; if (mem[4] !== 32'h11AB3344) $display("FAIL sb_mem: got %h want 11ab3344", mem[4]); else passed++;
  endtask

  task automatic test_subword_loads();
    logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001};
    logic [31:0] adr [6] = '{32'h22, 32'h22, 32'h22, 32'h20, 32'h21, 32'h20};
    logic [31:0] exp [6] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01, 32'h0000007F, 32'h00007F01};
    bit ok;
    poke(6'd8, 32'h80FF7F01);
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, f3[i], adr[i], 32'h0, ok);
      @(negedge clk);
      @(negedge clk);
      total++; if (!ok || bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.resp_rdata !== exp[i])
        $display("FAIL load_%0d f3=%b addr=%h: got v=%b e=%b rdata=%h want 1/0/%h",
                 i, f3[i], adr[i], bus.resp_valid, bus.resp_err, bus.resp_rdata, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_errors();
    logic        we  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3  [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0] adr [4] = '{32'h13, 32'h11, 32'h10, 32'h10};
    bit ok;
    for (int i = 0; i < 4; i++) begin
      issue(we[i], f3[i], adr[i], 32'hFFFFFFFF, ok);
      @(negedge clk);
      total++; if (!ok || {bus.resp_valid, bus.resp_err, bus.mem_read_en, bus.mem_write_en} !== 4'b1100 || bus.resp_rdata !== 32'h0)
        $display("FAIL err_%0d_c1: got v/e/re/we=%b rdata=%h want 1100/0", i,
                 {bus.resp_valid, bus.resp_err, bus.mem_read_en, bus.mem_write_en}, bus.resp_rdata);
      else passed++;
      @(negedge clk);
      total++; if ({bus.resp_valid, bus.resp_err, bus.req_ready} !== 3'b001)
        $display("FAIL err_%0d_c2: got v/e/r=%b want 001", i, {bus.resp_valid, bus.resp_err, bus.req_ready});
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] ready_seen;
    logic [11:0] valid_seen;
    logic [31:0] rd [3];
    int          acc_at [3];
    int          nresp = 0;
    int          nacc = 0;
    poke(6'd12, 32'hCAFEF00D);
    rd = '{32'hX, 32'hX, 32'hX};
    acc_at = '{-1, -1, -1};
    bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h30; bus.req_wdata = '0;
    bus.req_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      ready_seen[c] = bus.req_ready;
      valid_seen[c] = bus.resp_valid;
      if (bus.resp_valid === 1'b1 && nresp < 3) begin
        rd[nresp] = bus.resp_rdata;
        nresp++;
      end
      @(posedge clk);
      if (ready_seen[c] === 1'b1 && nacc < 3) begin
        acc_at[nacc] = c;
        nacc++;
        #1;
        case (nacc)
          1: begin bus.req_we = 1'b1; bus.req_funct3 = 3'b001; bus.req_addr = 32'h32; bus.req_wdata = 32'h00001234; end
          2: begin bus.req_we = 1'b0; bus.req_funct3 = 3'b100; bus.req_addr = 32'h33; bus.req_wdata = '0; end
          default: bus.req_valid = 1'b0;
        endcase
      end
    end
    bus.req_valid = 1'b0;
    total++; if (ready_seen !== 12'hC89) $display("FAIL b2b_ready: got %b want 110010001001", ready_seen); else passed++;
    total++; if (valid_seen !== 12'h244) $display("FAIL b2b_valid: got %b want 001001000100", valid_seen); else passed++;
    total++; if (acc_at[0] != 0 || acc_at[1] != 3 || acc_at[2] != 7)
      $display("FAIL b2b_accept: got %0d,%0d,%0d want 0,3,7", acc_at[0], acc_at[1], acc_at[2]); else passed++;
    total++; if (rd[0] !== 32'hCAFEF00D || rd[1] !== 32'h0 || rd[2] !== 32'h12)
      $display("FAIL b2b_rdata: got %h,%h,%h want cafef00d,0,12", rd[0], rd[1], rd[2]); else passed++;
    total++; if (mem[12] !== 32'h1234F00D) $display("FAIL b2b_mem: got %h want 1234f00d", mem[12]); else passed++;
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    poke(6'd16, 32'h55667788);
    issue(1'b1, 3'b000, 32'h40, 32'h99, ok);
    @(negedge clk);
    @(negedge clk);
    total++; if (!ok || bus.mem_write_en !== 1'b1 || bus.mem_write_data !== 32'h55667799)
      $display("FAIL rstw_write: got we=%b data=%h want 1/55667799", bus.mem_write_en, bus.mem_write_data); else passed++;
    rst = 1'b0;
    #1;
    total++; if ({bus.mem_write_en, bus.mem_read_en, bus.resp_valid, bus.req_ready} !== 4'b0001)
      $display("FAIL rstw_async: got we/re/v/r=%b want 0001", {bus.mem_write_en, bus.mem_read_en, bus.resp_valid, bus.req_ready}); else passed++;
    total++; if ({bus.mem_addr, bus.mem_write_data, bus.resp_rdata} !== 96'h0)
      $display("FAIL rstw_data: got %h want 0", {bus.mem_addr, bus.mem_write_data, bus.resp_rdata}); else passed++;
    @(negedge clk);
    total++; if (mem[16] !== 32'h55667788) $display("FAIL rstw_mem: got %h want 55667788", mem[16]); else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++; if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read_en, bus.mem_write_en} !== 5'b10000)
      $display("FAIL rstw_release: got %b want 10000", {bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read_en, bus.mem_write_en}); else passed++;
    issue(1'b0, 3'b010, 32'h40, 32'h0, ok);
    @(negedge clk);
    @(negedge clk);
    total++; if (!ok || bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h55667788)
      $display("FAIL rstw_lw: got v=%b rdata=%h want 1/55667788", bus.resp_valid, bus.resp_rdata); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    test_reset();
    test_sw_lw();
    test_sb_rmw();
    test_subword_loads();
    test_errors();
    test_back_to_back();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
